// File: rtl/uar_rx_ctrl.sv
// rtl/uar_rx_ctrl.sv - UART receive sequencer on the 16x clock: sync, start check, mid-bit sampling, handshake
// Optional parity stage and parity_err port enabled by defining UAR_PARITY_EN.
module uar_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int MID_SAMPLE = 7
) (
    input  logic                 clk_16x,
    input  logic                 rst_p,
    input  logic                 rx_in,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun_err,
`ifdef UAR_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        STOP   = 5'b01000
`ifdef UAR_PARITY_EN
       ,PARITY = 5'b10000
`endif
    } state_t;

    localparam logic [3:0] MID      = 4'(MID_SAMPLE);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q, rx_d_q;
    logic [3:0]             sample_cnt_q, sample_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_err_q, overrun_err_d;
    logic                   busy_q, busy_d;
    logic                   par_bad_q, par_bad_d;
    logic                   parity_err_q, parity_err_d;

    always_comb begin
        state_d       = state_q;
        sample_cnt_d  = sample_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        par_bad_d     = par_bad_q;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;
        parity_err_d  = 1'b0;

        if (rx_ack && rx_valid_q) rx_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                par_bad_d = 1'b0;
                if (!rx_s_q && rx_d_q) begin
                    state_d      = START;
                    sample_cnt_d = 4'd0;
                end
            end
            START: begin
                sample_cnt_d = sample_cnt_q + 4'd1;
                if (sample_cnt_q == MID) begin
                    if (!rx_s_q) begin
                        state_d      = DATA;
                        sample_cnt_d = 4'd0;
                        bit_cnt_d    = 4'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                sample_cnt_d = sample_cnt_q + 4'd1;
                if (sample_cnt_q == 4'd15) begin
                    shreg_d   = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UAR_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                        sample_cnt_d = 4'd0;
                    end
                end
            end
`ifdef UAR_PARITY_EN
            PARITY: begin
                sample_cnt_d = sample_cnt_q + 4'd1;
                if (sample_cnt_q == 4'd15) begin
                    par_bad_d    = ^{shreg_q, rx_s_q};
                    state_d      = STOP;
                    sample_cnt_d = 4'd0;
                end
            end
`endif
            STOP: begin
                sample_cnt_d = sample_cnt_q + 4'd1;
                if (sample_cnt_q == 4'd15) begin
                    state_d = IDLE;
                    // Framing beats parity beats overrun; only a clean frame may load.
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                    end else if (rx_valid_q && !rx_ack) begin
                        overrun_err_d = 1'b1;
                    end else begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_16x) begin
        if (rst_p) begin
            state_q       <= IDLE;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_d_q        <= 1'b1;
            sample_cnt_q  <= 4'd0;
            bit_cnt_q     <= 4'd0;
            shreg_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
            par_bad_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_meta_q     <= rx_in;
            rx_s_q        <= rx_meta_q;
            rx_d_q        <= rx_s_q;
            sample_cnt_q  <= sample_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
            parity_err_q  <= parity_err_d;
            par_bad_q     <= par_bad_d;
            busy_q        <= busy_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
    assign busy        = busy_q;
`ifdef UAR_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    logic unused_parity;
    assign unused_parity = ^{parity_err_q, par_bad_q, parity_err_d, par_bad_d};
`endif

endmodule

// File: tb/tb_uar_rx_ctrl.sv
// tb/tb_uar_rx_ctrl.sv - scoreboard bench for uar_rx_ctrl
module tb_uar_rx_ctrl;

    localparam int DB = 8;
`ifdef UAR_PARITY_EN
    localparam int STOP_OFS = 171;
`else
    localparam int STOP_OFS = 155;
`endif
    localparam int K_GOOD = 0, K_FRAME = 1, K_OVR = 2, K_PAR = 3;

    logic          clk_16x = 1'b0;
    logic          rst_p   = 1'b1;
    logic          rx_in   = 1'b1;
    logic          rx_ack  = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid, frame_err, overrun_err, busy;
`ifdef UAR_PARITY_EN
    logic          parity_err;
`else
    logic          parity_err = 1'b0;
`endif

    uar_rx_ctrl #(.DATA_BITS(DB), .MID_SAMPLE(7)) dut (
        .clk_16x    (clk_16x),
        .rst_p      (rst_p),
        .rx_in      (rx_in),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
`ifdef UAR_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk_16x = ~clk_16x;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk_16x) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        logic [7:0]  data;
        int          cyc;
    } ev_t;
    ev_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_16x);
            #1;
        end
    endtask

    task automatic got_event(input int kind, input logic [7:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("evt_expected", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("evt_kind", 32'(kind), 32'(e.kind));
            check("evt_cycle", 32'(cyc), 32'(e.cyc));
            if (e.kind == K_GOOD) check("evt_data", {24'd0, data}, {24'd0, e.data});
        end
    endtask

    logic          prev_valid = 1'b0;
    logic [DB-1:0] prev_data  = '0;
    always @(negedge clk_16x) begin
        if (frame_err || overrun_err || parity_err)
            check("err_exclusive", 32'(frame_err + overrun_err + parity_err), 32'd1);
        if (frame_err)   got_event(K_FRAME, 8'd0);
        if (overrun_err) got_event(K_OVR, 8'd0);
        if (parity_err)  got_event(K_PAR, 8'd0);
        if (rx_valid && (!prev_valid || rx_data != prev_data)) got_event(K_GOOD, rx_data);
        prev_valid = rx_valid;
        prev_data  = rx_data;
    end

    // One 16-cycle-per-bit frame; first line change lands 1 time unit after an edge.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                              input logic ack_at_stop, input int kind);
        ev_t e;
        logic pbit;
        rx_in = 1'b1;
        step(4);
        e.kind = kind;
        e.data = d;
        e.cyc  = cyc + STOP_OFS;
        if (kind >= 0) exp_q.push_back(e);
        rx_in = 1'b0;
        step(16);
        for (int i = 0; i < DB; i++) begin
            rx_in = d[i];
            step(16);
        end
`ifdef UAR_PARITY_EN
        pbit  = (^d) ^ par_flip;
        rx_in = pbit;
        step(16);
`else
        pbit = par_flip;
`endif
        rx_in = stop_b;
        for (int i = 0; i < 16; i++) begin
            rx_ack = ack_at_stop && (i == 10);
            step(1);
        end
        rx_ack = 1'b0;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        step(1);
        rx_ack = 1'b0;
    endtask

    initial begin
        repeat (20000) @(posedge clk_16x);
        $display("FAIL watchdog: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end

    int c0;
    initial begin
        step(3);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_p = 1'b0;
        step(5);

        // 1: good 0x55, then ack clears next cycle; stray ack ignored
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, K_GOOD);
        check("t1_valid", 32'(rx_valid), 32'd1);
        check("t1_data", 32'(rx_data), 32'h55);
        pulse_ack();
        check("t1_ack_clears", 32'(rx_valid), 32'd0);
        pulse_ack();
        check("t1_ack_idle", 32'(rx_valid), 32'd0);

        // 2: 4-cycle low glitch rejected at E0+8
        step(4);
        c0 = cyc;
        rx_in = 1'b0;
        step(4);
        rx_in = 1'b1;
        while (cyc < c0 + 3) step(1);
        check("t2_busy_start", 32'(busy), 32'd1);
        while (cyc < c0 + 10) step(1);
        check("t2_busy_before_chk", 32'(busy), 32'd1);
        step(1);
        check("t2_busy_idle", 32'(busy), 32'd0);
        check("t2_valid", 32'(rx_valid), 32'd0);

        // 3: bad stop bit, line then held low
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0, K_FRAME);
        check("t3_valid", 32'(rx_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(10);
            check("t3_low_no_start", 32'(busy), 32'd0);
        end
        rx_in = 1'b1;
        step(20);
        check("t3_high_idle", 32'(busy), 32'd0);

        // 4: overrun without ack, then a frame acked on its stop edge
        send_frame(8'h12, 1'b1, 1'b0, 1'b0, K_GOOD);
        send_frame(8'h34, 1'b1, 1'b0, 1'b0, K_OVR);
        check("t4_keep_old", 32'(rx_data), 32'h12);
        check("t4_valid", 32'(rx_valid), 32'd1);
        send_frame(8'h34, 1'b1, 1'b0, 1'b1, K_GOOD);
        check("t4_ack_load", 32'(rx_data), 32'h34);
        check("t4_ack_valid", 32'(rx_valid), 32'd1);
        pulse_ack();
        check("t4_cleared", 32'(rx_valid), 32'd0);

        // 5: reset mid-frame during data bit 4 of 0xFF
        step(4);
        rx_in = 1'b0;
        step(16);
        rx_in = 1'b1;
        step(16 * 4 + 8);
        check("t5_busy_mid", 32'(busy), 32'd1);
        rst_p = 1'b1;
        step(3);
        rst_p = 1'b0;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_valid", 32'(rx_valid), 32'd0);
        check("t5_rst_data", 32'(rx_data), 32'd0);
        step(20);
        check("t5_no_false_start", 32'(busy), 32'd0);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0, K_GOOD);
        check("t5_data", 32'(rx_data), 32'h0F);
        pulse_ack();

`ifdef UAR_PARITY_EN
        // 6: odd total parity rejected, correct parity accepted
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, K_PAR);
        check("t6_par_valid", 32'(rx_valid), 32'd0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, K_GOOD);
        check("t6_data", 32'(rx_data), 32'h07);
        pulse_ack();
`endif

        step(30);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
